axi_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one single-beat AXI4-Lite read/write engine among `N_REQ` requesters. Each requester is, for example, a front-panel scanner, LED driver or bench stimulus. The block accepts one command at a time and issues it to the engine as a one-cycle rd/wr pulse. It waits for completion, with a timeout, and routes the read data and response back to the originating requester.

---
 rtl/axi_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 32 +++
 rtl/axi_req_arbiter.sv | 141 ++++++++++++++
 tb/tb_axi_req_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and response codes for the AXI4-Lite request arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: searches upward from last+1 (mod N_REQ)
// and returns the first pending request as a one-hot grant plus its index.
module rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int unsigned IW = $clog2(N_REQ);

  int unsigned j;
  logic        found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      j = (int'(last) + i) % N_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/axi_req_arbiter.sv
// Shares one single-beat AXI4-Lite engine among N_REQ requesters: round-robin
// accept, one-cycle strobe, bounded wait for completion, response routed back.
module axi_req_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_wr,
  input  logic [N_REQ-1:0][31:0] req_addr,
  input  logic [N_REQ-1:0][31:0] req_wdata,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic [1:0]             rsp_resp,
  output logic                   rsp_timeout,
  output logic                   eng_rd,
  output logic                   eng_wr,
  output logic [31:0]            eng_addr,
  output logic [31:0]            eng_wdata,
  output logic                   eng_abort,
  input  logic                   eng_done,
  input  logic [31:0]            eng_rdata,
  input  logic [1:0]             eng_resp
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0]    CntMax = CW'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] Gnt0   = N_REQ'(1);

  arb_state_t       state_q;
  logic [IW-1:0]    last_q;
  logic [IW-1:0]    win_q;
  logic             wr_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic [1:0]       resp_q;
  logic             tmo_q;
  logic [CW-1:0]    cnt_q;
  logic             eng_rd_q;
  logic             eng_wr_q;
  logic [N_REQ-1:0] rsp_valid_q;

  logic [N_REQ-1:0] pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             at_limit;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req  (req_valid),
    .last (last_q),
    .grant(pick_grant),
    .idx  (pick_idx)
  );

  assign at_limit = (cnt_q == CntMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IW'(N_REQ - 1);
      win_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
      tmo_q       <= 1'b0;
      cnt_q       <= '0;
      eng_rd_q    <= 1'b0;
      eng_wr_q    <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      eng_rd_q    <= 1'b0;
      eng_wr_q    <= 1'b0;
      rsp_valid_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (|req_valid) begin
            win_q    <= pick_idx;
            last_q   <= pick_idx;
            wr_q     <= req_wr[pick_idx];
            addr_q   <= req_addr[pick_idx];
            wdata_q  <= req_wdata[pick_idx];
            // Strobe is registered so it lands in the ISSUE cycle.
            eng_rd_q <= ~req_wr[pick_idx];
            eng_wr_q <= req_wr[pick_idx];
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (!at_limit) begin
            cnt_q <= cnt_q + CW'(1);
          end
          if (eng_done) begin
            rdata_q     <= wr_q ? 32'h0 : eng_rdata;
            resp_q      <= eng_resp;
            tmo_q       <= 1'b0;
            rsp_valid_q <= Gnt0 << win_q;
            state_q     <= RESP;
          end else if (at_limit) begin
            rdata_q     <= 32'h0;
            resp_q      <= RESP_SLVERR;
            tmo_q       <= 1'b1;
            rsp_valid_q <= Gnt0 << win_q;
            state_q     <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Gated by rst so no grant leaks out while reset is held.
  assign req_ready   = (state_q == IDLE && !rst) ? pick_grant : '0;
  assign eng_abort   = (state_q == WAIT) && at_limit && !eng_done;
  assign eng_rd      = eng_rd_q;
  assign eng_wr      = eng_wr_q;
  assign eng_addr    = addr_q;
  assign eng_wdata   = wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = (state_q == RESP) ? rdata_q : 32'h0;
  assign rsp_resp    = (state_q == RESP) ? resp_q : RESP_OKAY;
  assign rsp_timeout = (state_q == RESP) && tmo_q;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Scoreboard bench for axi_req_arbiter: directed requesters, a scripted engine,
// and independent monitors for grants, strobes, aborts and responses.
module tb_axi_req_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_wr;
  logic [N-1:0][31:0] req_addr;
  logic [N-1:0][31:0] req_wdata;
  logic [N-1:0]       req_ready;
  logic [N-1:0]       rsp_valid;
  logic [31:0]        rsp_rdata;
  logic [1:0]         rsp_resp;
  logic               rsp_timeout;
  logic               eng_rd;
  logic               eng_wr;
  logic [31:0]        eng_addr;
  logic [31:0]        eng_wdata;
  logic               eng_abort;
  logic               eng_done;
  logic [31:0]        eng_rdata;
  logic [1:0]         eng_resp;

  axi_req_arbiter #(
    .N_REQ  (N),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .rsp_timeout(rsp_timeout),
    .eng_rd     (eng_rd),
    .eng_wr     (eng_wr),
    .eng_addr   (eng_addr),
    .eng_wdata  (eng_wdata),
    .eng_abort  (eng_abort),
    .eng_done   (eng_done),
    .eng_rdata  (eng_rdata),
    .eng_resp   (eng_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
    int          lat;
  } rsp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } stb_t;

  rsp_t exp_rsp[$];
  stb_t exp_stb[$];
  int   exp_gnt[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_acc = 0;
  int t_stb = 0;
  int abort_n = 0;
  int exp_abort_n = 0;
  int last_gnt_cyc = -1;
  logic tput_chk = 1'b0;

  logic [N-1:0] acc = '0;
  int           rem[N];

  // Engine script: done arrives cfg_delay cycles after the strobe; 0 = never.
  int          cfg_delay = 1;
  logic [31:0] cfg_rdata = 32'h0;
  logic [1:0]  cfg_resp  = 2'b00;
  logic        cfg_stray = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = (r == -1) ? i : -2;
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requesters: drop valid once all queued commands are accepted.
  initial forever begin
    tick();
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        acc[i] = 1'b0;
        rem[i]--;
        if (rem[i] <= 0) req_valid[i] = 1'b0;
        else req_addr[i] = req_addr[i] + 32'h100;
      end
    end
  end

  initial begin
    int cnt = 0;
    logic pend = 1'b0;
    forever begin
      tick();
      eng_done  = 1'b0;
      eng_rdata = cfg_rdata;
      eng_resp  = cfg_resp;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (cfg_stray) begin
          eng_done  = 1'b1;
          cfg_stray = 1'b0;
        end
        if (pend) begin
          if (cnt == 0) begin
            eng_done = 1'b1;
            pend     = 1'b0;
          end else begin
            cnt--;
          end
        end
        if ((eng_rd || eng_wr) && cfg_delay > 0) begin
          pend = 1'b1;
          cnt  = cfg_delay - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && |req_ready) begin
      int g;
      g = onehot_idx(req_ready);
      check("grant_onehot", $countones(req_ready), 1);
      if (exp_gnt.size() == 0) begin
        note_fail("grant_unexpected");
      end else begin
        check("grant_idx", g, exp_gnt.pop_front());
        if (tput_chk && last_gnt_cyc >= 0) check("grant_spacing", cyc - last_gnt_cyc, 4);
        last_gnt_cyc = cyc;
        t_acc = cyc;
        if (g >= 0) acc[g] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (eng_rd || eng_wr)) begin
      stb_t e;
      check("strobe_excl", {31'h0, eng_rd & eng_wr}, 0);
      if (exp_stb.size() == 0) begin
        note_fail("strobe_unexpected");
      end else begin
        e = exp_stb.pop_front();
        check("strobe_wr", {31'h0, eng_wr}, {31'h0, e.wr});
        check("strobe_addr", eng_addr, e.addr);
        check("strobe_wdata", eng_wdata, e.wdata);
        check("strobe_latency", cyc - t_acc, 1);
        t_stb = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && eng_abort) begin
      abort_n++;
      check("abort_time", cyc - t_stb, TO);
    end
  end

  always @(negedge clk) begin
    if (!rst && |rsp_valid) begin
      rsp_t e;
      check("rsp_onehot", $countones(rsp_valid), 1);
      if (exp_rsp.size() == 0) begin
        note_fail("rsp_unexpected");
      end else begin
        e = exp_rsp.pop_front();
        check("rsp_idx", onehot_idx(rsp_valid), e.idx);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_resp", {30'h0, rsp_resp}, {30'h0, e.resp});
        check("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, e.tmo});
        check("rsp_latency", cyc - t_stb, e.lat);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_gnt.size() == 0 && exp_stb.size() == 0 && exp_rsp.size() == 0) break;
      tick();
    end
    if (exp_gnt.size() != 0 || exp_stb.size() != 0 || exp_rsp.size() != 0) begin
      note_fail("drain_timeout");
      exp_gnt.delete();
      exp_stb.delete();
      exp_rsp.delete();
    end
    repeat (2) tick();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic issue(input int i, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int n);
    req_wr[i]    = wr;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    rem[i]       = n;
    req_valid[i] = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;

    @(negedge clk);
    check("reset_ctrl", {req_ready, rsp_valid, eng_rd, eng_wr, eng_abort, rsp_timeout}, 0);
    check("reset_data", eng_addr | eng_wdata | rsp_rdata | {30'h0, rsp_resp}, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single read; a stray done while idle must produce nothing.
    cfg_delay = 1;
    cfg_rdata = 32'hDEAD_BEEF;
    cfg_resp  = 2'b00;
    cfg_stray = 1'b1;
    repeat (3) tick();
    exp_gnt.push_back(0);
    exp_stb.push_back('{1'b0, 32'h43C0_0010, 32'h0});
    exp_rsp.push_back('{0, 32'hDEAD_BEEF, 2'b00, 1'b0, 2});
    issue(0, 1'b0, 32'h43C0_0010, 32'h0, 1);
    drain();
    check("addr_hold_idle", eng_addr, 32'h43C0_0010);

    // Two simultaneous writes; engine rdata must be forced to zero.
    do_reset();
    cfg_delay = 2;
    cfg_rdata = 32'hFFFF_FFFF;
    exp_gnt.push_back(0);
    exp_gnt.push_back(2);
    exp_stb.push_back('{1'b1, 32'h0000_0100, 32'h11});
    exp_stb.push_back('{1'b1, 32'h0000_0200, 32'h22});
    exp_rsp.push_back('{0, 32'h0, 2'b00, 1'b0, 3});
    exp_rsp.push_back('{2, 32'h0, 2'b00, 1'b0, 3});
    issue(0, 1'b1, 32'h100, 32'h11, 1);
    issue(2, 1'b1, 32'h200, 32'h22, 1);
    drain();

    // All four requesters held for 12 commands at full throughput.
    do_reset();
    cfg_delay    = 1;
    cfg_rdata    = 32'h1234_5678;
    tput_chk     = 1'b1;
    last_gnt_cyc = -1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin
        exp_gnt.push_back(i);
        exp_stb.push_back('{1'b0, 32'h1000 + 32'(i) * 32'h10 + 32'(k) * 32'h100, 32'h0});
        exp_rsp.push_back('{i, 32'h1234_5678, 2'b00, 1'b0, 2});
      end
    end
    for (int i = 0; i < N; i++) issue(i, 1'b0, 32'h1000 + 32'(i) * 32'h10, 32'h0, 3);
    drain();
    tput_chk = 1'b0;

    // Engine never completes: abort at T1+TIMEOUT, SLVERR response.
    do_reset();
    cfg_delay = 0;
    exp_abort_n++;
    exp_gnt.push_back(1);
    exp_stb.push_back('{1'b0, 32'h2000, 32'h0});
    exp_rsp.push_back('{1, 32'h0, 2'b10, 1'b1, TO + 1});
    issue(1, 1'b0, 32'h2000, 32'h0, 1);
    drain();
    cfg_delay = 1;
    cfg_rdata = 32'hCAFE_0001;
    exp_gnt.push_back(2);
    exp_stb.push_back('{1'b0, 32'h3000, 32'h0});
    exp_rsp.push_back('{2, 32'hCAFE_0001, 2'b00, 1'b0, 2});
    issue(2, 1'b0, 32'h3000, 32'h0, 1);
    drain();

    // Done on the limit cycle beats the timeout.
    cfg_delay = TO;
    cfg_rdata = 32'h0BAD_F00D;
    cfg_resp  = 2'b01;
    exp_gnt.push_back(3);
    exp_stb.push_back('{1'b0, 32'h4000, 32'h0});
    exp_rsp.push_back('{3, 32'h0BAD_F00D, 2'b01, 1'b0, TO + 1});
    issue(3, 1'b0, 32'h4000, 32'h0, 1);
    drain();

    // Reset mid-WAIT drops the transaction; requester 0 wins afterwards.
    cfg_delay = 0;
    cfg_resp  = 2'b00;
    exp_gnt.push_back(1);
    exp_stb.push_back('{1'b0, 32'h5000, 32'h0});
    issue(1, 1'b0, 32'h5000, 32'h0, 1);
    repeat (7) tick();
    issue(0, 1'b0, 32'h6000, 32'h0, 1);
    issue(3, 1'b0, 32'h7000, 32'h0, 1);
    rst = 1'b1;
    #1;
    check("rst_ctrl", {req_ready, rsp_valid, eng_rd, eng_wr, eng_abort, rsp_timeout}, 0);
    check("rst_data", eng_addr | eng_wdata | rsp_rdata | {30'h0, rsp_resp}, 0);
    tick();
    tick();
    cfg_delay = 1;
    cfg_rdata = 32'h600D_0000;
    exp_gnt.push_back(0);
    exp_gnt.push_back(3);
    exp_stb.push_back('{1'b0, 32'h6000, 32'h0});
    exp_stb.push_back('{1'b0, 32'h7000, 32'h0});
    exp_rsp.push_back('{0, 32'h600D_0000, 2'b00, 1'b0, 2});
    exp_rsp.push_back('{3, 32'h600D_0000, 2'b00, 1'b0, 2});
    rst = 1'b0;
    drain();

    check("abort_count", abort_n, exp_abort_n);
    check("gnt_queue_empty", exp_gnt.size(), 0);
    check("rsp_queue_empty", exp_rsp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
